// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle FETCH / DECODE / EXEC / WB controller for the 8-bit datapath.
// Fetches one instruction at a time from instruction memory, drives the
// 2-entry x 8-bit register file and holds the PC and zero flag.
//
// Instruction word: [7:6] op, [5] rd, [4] rs, [3:0] imm4
//   00 ADD  rd = rd + rs          01 SUB  rd = rd - rs
//   10 LDI  rd = {4'h0, imm4}     11 JZ   if Z: PC = {2'b00, [5:0]}
//   8'hFF   HALT (terminal until rst)
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   imem_req/addr     fetch request and address (address = PC)
//   imem_valid/data   instruction return; only looked at in FETCH
//   rf_read_reg1/2    register file read selects
//   rf_read_data1/2   register file combinational read data
//   rf_reg_write      register file write enable (WB state only)
//   rf_write_reg/data register file write select / data
//   zero_flag         Z from the last ADD/SUB/LDI
//   halted            high while in HALT
//   fetch_err         sticky fetch timeout flag
//
// Build option: define IMEM_TIMEOUT_EN to enable the fetch wait counter.
// After TIMEOUT_CYCLES consecutive FETCH cycles without imem_valid the
// sequencer sets fetch_err and halts. Without the macro FETCH waits forever
// and fetch_err is tied low.
// -----------------------------------------------------------------------------
module instr_sequencer #(
   parameter logic [7:0] PC_RESET       = 8'h00,
   parameter int         TIMEOUT_CYCLES = 15
) (
   input  logic       clk,
   input  logic       rst,
   output logic       imem_req,
   output logic [7:0] imem_addr,
   input  logic       imem_valid,
   input  logic [7:0] imem_data,
   output logic       rf_read_reg1,
   output logic       rf_read_reg2,
   output logic       rf_reg_write,
   output logic       rf_write_reg,
   output logic [7:0] rf_write_data,
   input  logic [7:0] rf_read_data1,
   input  logic [7:0] rf_read_data2,
   output logic       zero_flag,
   output logic       halted,
   output logic       fetch_err
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_WB     = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("instr_sequencer: TIMEOUT_CYCLES must be at least 1");
   end

   state_t     r_state, w_state_nxt;
   logic [7:0] r_pc, w_pc_nxt;
   logic [7:0] r_ir, w_ir_nxt;
   logic [7:0] r_result, w_result_nxt;
   logic       r_zero, w_zero_nxt;

   logic       w_is_jz;
   logic       w_is_halt;
   logic [7:0] w_alu;

   // Result for ADD/SUB/LDI; carry and borrow are discarded (modulo 256).
   function automatic logic [7:0] f_alu(input logic [7:0] ir,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
      logic [7:0] res;
      case (ir[7:6])
         2'b00:   res = a + b;
         2'b01:   res = a - b;
         default: res = {4'h0, ir[3:0]};
      endcase
      return res;
   endfunction

   assign w_is_halt = (r_ir[7:6] == 2'b11) && (r_ir[5:0] == 6'h3F);
   assign w_is_jz   = (r_ir[7:6] == 2'b11) && !w_is_halt;
   assign w_alu     = f_alu(r_ir, rf_read_data1, rf_read_data2);

`ifdef IMEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 4) ? 4 : $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
   logic             r_fetch_err, w_fetch_err_nxt;
`endif

   // Next-state, datapath next values and outputs
   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_ir_nxt      = r_ir;
      w_result_nxt  = r_result;
      w_zero_nxt    = r_zero;
      imem_req      = 1'b0;
      rf_read_reg1  = 1'b0;
      rf_read_reg2  = 1'b0;
      rf_reg_write  = 1'b0;
      rf_write_reg  = 1'b0;
      rf_write_data = 8'h00;
`ifdef IMEM_TIMEOUT_EN
      w_wait_cnt_nxt  = r_wait_cnt;
      w_fetch_err_nxt = r_fetch_err;
`endif

      case (r_state)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_valid) begin
               w_ir_nxt    = imem_data;
               w_pc_nxt    = r_pc + 8'd1;
               w_state_nxt = S_DECODE;
            end
`ifdef IMEM_TIMEOUT_EN
            // The count of stalled cycles already taken includes this one
            // when it equals TIMEOUT_CYCLES-1.
            else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               w_fetch_err_nxt = 1'b1;
               w_state_nxt     = S_HALT;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + 1'b1;
            end
`endif
         end
         S_DECODE: begin
            rf_read_reg1 = r_ir[5];
            rf_read_reg2 = r_ir[4];
            if (w_is_halt) begin
               w_state_nxt = S_HALT;
            end else if (w_is_jz) begin
               if (r_zero) begin
                  w_pc_nxt = {2'b00, r_ir[5:0]};
               end
               w_state_nxt = S_FETCH;
            end else begin
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            rf_read_reg1 = r_ir[5];
            rf_read_reg2 = r_ir[4];
            w_result_nxt = w_alu;
            w_zero_nxt   = (w_alu == 8'h00);
            w_state_nxt  = S_WB;
         end
         S_WB: begin
            rf_read_reg1  = r_ir[5];
            rf_reg_write  = 1'b1;
            rf_write_reg  = r_ir[5];
            rf_write_data = r_result;
            w_state_nxt   = S_FETCH;
         end
         S_HALT: begin
            w_state_nxt = S_HALT;
         end
         default: begin
            w_state_nxt = S_FETCH;
         end
      endcase

`ifdef IMEM_TIMEOUT_EN
      // Holding the counter at zero outside FETCH clears it on every entry.
      if (r_state != S_FETCH) begin
         w_wait_cnt_nxt = '0;
      end
`endif

      // While reset is held the outputs already show the post-reset view,
      // so no writeback can leak out of an interrupted instruction.
      if (rst) begin
         imem_req      = 1'b1;
         rf_read_reg1  = 1'b0;
         rf_read_reg2  = 1'b0;
         rf_reg_write  = 1'b0;
         rf_write_reg  = 1'b0;
         rf_write_data = 8'h00;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_FETCH;
         r_pc     <= PC_RESET;
         r_ir     <= 8'h00;
         r_result <= 8'h00;
         r_zero   <= 1'b0;
`ifdef IMEM_TIMEOUT_EN
         r_wait_cnt  <= '0;
         r_fetch_err <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_pc     <= w_pc_nxt;
         r_ir     <= w_ir_nxt;
         r_result <= w_result_nxt;
         r_zero   <= w_zero_nxt;
`ifdef IMEM_TIMEOUT_EN
         r_wait_cnt  <= w_wait_cnt_nxt;
         r_fetch_err <= w_fetch_err_nxt;
`endif
      end
   end

   assign imem_addr = rst ? PC_RESET : r_pc;
   assign zero_flag = r_zero;
   assign halted    = (r_state == S_HALT);

`ifdef IMEM_TIMEOUT_EN
   assign fetch_err = r_fetch_err;
`else
   assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//
// Drives instr_sequencer with an instruction memory model and a 2 x 8-bit
// register file model. Every accepted fetch is executed by an architectural
// model; the writeback it implies is queued and compared when the sequencer
// asserts rf_reg_write.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic       imem_valid;
   logic [7:0] imem_data;
   logic       rf_read_reg1, rf_read_reg2;
   logic       rf_reg_write, rf_write_reg;
   logic [7:0] rf_write_data;
   logic [7:0] rf_read_data1, rf_read_data2;
   logic       zero_flag, halted, fetch_err;

   instr_sequencer #(.PC_RESET(8'h00), .TIMEOUT_CYCLES(15)) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_valid    (imem_valid),
      .imem_data     (imem_data),
      .rf_read_reg1  (rf_read_reg1),
      .rf_read_reg2  (rf_read_reg2),
      .rf_reg_write  (rf_reg_write),
      .rf_write_reg  (rf_write_reg),
      .rf_write_data (rf_write_data),
      .rf_read_data1 (rf_read_data1),
      .rf_read_data2 (rf_read_data2),
      .zero_flag     (zero_flag),
      .halted        (halted),
      .fetch_err     (fetch_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       z;
      logic       rd;
      logic [7:0] data;
   } wb_t;

   logic [7:0] mem [256];
   logic [7:0] rf [2];
   logic [7:0] m_reg [2];
   logic [7:0] m_commit [2];
   logic       m_z;
   logic [7:0] m_pc;
   logic [7:0] last_addr;
   wb_t        wb_q[$];
   int         wb_cyc[$];
   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         fetch_cnt = 0;
   int         stall_cnt = 0;
   int         wait_left = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Register file model: combinational read, write on the rising edge.
   assign rf_read_data1 = rf[rf_read_reg1];
   assign rf_read_data2 = rf[rf_read_reg2];
   always @(posedge clk) begin
      if (rf_reg_write) rf[rf_write_reg] <= rf_write_data;
      cyc <= cyc + 1;
   end

   // Architectural effect of one accepted instruction.
   task automatic model_exec(input logic [7:0] d);
      logic [7:0] res;
      m_pc = m_pc + 8'd1;
      if (d[7:6] == 2'b11) begin
         if (d[5:0] != 6'h3F && m_z) m_pc = {2'b00, d[5:0]};
      end else begin
         if (d[7:6] == 2'b00)      res = m_reg[d[5]] + m_reg[d[4]];
         else if (d[7:6] == 2'b01) res = m_reg[d[5]] - m_reg[d[4]];
         else                      res = {4'h0, d[3:0]};
         m_reg[d[5]] = res;
         m_z = (res == 8'h00);
         wb_q.push_back('{z: m_z, rd: d[5], data: res});
      end
   endtask

   // Instruction memory driver; wait_left inserts stall cycles.
   initial begin
      imem_valid = 1'b0;
      imem_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            imem_valid = 1'b0;
         end else if (imem_req) begin
            if (wait_left > 0) begin
               wait_left--;
               stall_cnt++;
               imem_valid = 1'b0;
               imem_data  = 8'($urandom);
               chk("stall_addr", 32'(imem_addr), 32'(m_pc));
            end else begin
               chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
               last_addr  = imem_addr;
               imem_valid = 1'b1;
               imem_data  = mem[imem_addr];
               fetch_cnt++;
               model_exec(mem[imem_addr]);
            end
         end else begin
            // Junk outside FETCH must be ignored.
            imem_valid = 1'($urandom_range(0, 1));
            imem_data  = 8'($urandom);
         end
      end
   end

   // Writeback monitor: pops the scoreboard.
   initial begin
      wb_t e;
      forever begin
         @(negedge clk);
         if (rf_reg_write !== 1'b0) begin
            wb_cyc.push_back(cyc);
            chk("wb_expected", 32'(wb_q.size() != 0), 32'd1);
            if (wb_q.size() != 0) begin
               e = wb_q.pop_front();
               chk("wb_reg", 32'(rf_write_reg), 32'(e.rd));
               chk("wb_data", 32'(rf_write_data), 32'(e.data));
               chk("wb_zero", 32'(zero_flag), 32'(e.z));
               m_commit[e.rd] = e.data;
            end
         end
      end
   end

   task automatic clear_mem(input logic [7:0] v);
      for (int i = 0; i < 256; i++) mem[i] = v;
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      rst       = 1'b1;
      m_pc      = 8'h00;
      m_z       = 1'b0;
      m_reg     = m_commit;
      wait_left = 0;
      wb_q.delete();
      @(posedge clk);
      @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'd1);
      chk("rst_addr", 32'(imem_addr), 32'h00);
      chk("rst_we", 32'(rf_reg_write), 32'd0);
      chk("rst_sel1", 32'(rf_read_reg1), 32'd0);
      chk("rst_sel2", 32'(rf_read_reg2), 32'd0);
      chk("rst_wdata", 32'(rf_write_data), 32'h00);
      chk("rst_zero", 32'(zero_flag), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_ferr", 32'(fetch_err), 32'd0);
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic run_to_halt(input int budget);
      int n = 0;
      while (halted !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("halt_reached", 32'(halted), 32'd1);
      repeat (10) @(negedge clk);
      chk("halt_held", 32'(halted), 32'd1);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("wb_pending", 32'(wb_q.size()), 32'd0);
      chk("halt_zero", 32'(zero_flag), 32'(m_z));
   endtask

   task automatic wait_fetches(input int target, input int budget);
      int n = 0;
      while (fetch_cnt < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk("fetch_budget", 32'(fetch_cnt >= target), 32'd1);
   endtask

   initial begin
      int base, f0, s0, w0;
      m_commit[0] = 8'h00;
      m_commit[1] = 8'h00;
      rf[0]       = 8'h00;
      rf[1]       = 8'h00;

      // LDI r0,5 ; LDI r1,3 ; ADD r0,r1 ; HALT
      clear_mem(8'hFF);
      mem[0] = 8'h85; mem[1] = 8'hB3; mem[2] = 8'h10;
      do_reset(2);
      base = wb_cyc.size();
      run_to_halt(100);
      chk("t1_nwb", 32'(wb_cyc.size() - base), 32'd3);
      if (wb_cyc.size() >= base + 3) begin
         chk("t1_gap1", 32'(wb_cyc[base+1] - wb_cyc[base]), 32'd4);
         chk("t1_gap2", 32'(wb_cyc[base+2] - wb_cyc[base+1]), 32'd4);
      end
      chk("t1_r0", 32'(rf[0]), 32'h08);
      chk("t1_r1", 32'(rf[1]), 32'h03);

      // SUB to zero, JZ taken to 8'h20
      clear_mem(8'hFF);
      mem[0] = 8'h83; mem[1] = 8'hB3; mem[2] = 8'h50; mem[3] = 8'hE0;
      do_reset(1);
      run_to_halt(100);
      chk("t2_r0", 32'(rf[0]), 32'h00);
      chk("t2_zero", 32'(zero_flag), 32'd1);
      chk("t2_target", 32'(last_addr), 32'h20);

      // SUB to one, JZ falls through
      mem[1] = 8'hB2;
      do_reset(1);
      run_to_halt(100);
      chk("t2b_r0", 32'(rf[0]), 32'h01);
      chk("t2b_zero", 32'(zero_flag), 32'd0);
      chk("t2b_fall", 32'(last_addr), 32'h04);

      // r0 = 0 - 1 = FF ; r1 = 2 ; ADD wraps to 01
      clear_mem(8'hFF);
      mem[0] = 8'hB1; mem[1] = 8'h80; mem[2] = 8'h50; mem[3] = 8'hB2; mem[4] = 8'h10;
      do_reset(1);
      run_to_halt(100);
      chk("t3_r0", 32'(rf[0]), 32'h01);
      chk("t3_zero", 32'(zero_flag), 32'd0);

      // PC wrap: untaken JZ everywhere, PC walks 01..FF then back to 00
      clear_mem(8'hC0);
      mem[0] = 8'hB1;
      do_reset(1);
      f0 = fetch_cnt;
      wait_fetches(f0 + 257, 2000);
      chk("wrap_addr", 32'(last_addr), 32'h00);

      // Five stall cycles before the first instruction arrives
      clear_mem(8'hFF);
      mem[0] = 8'h85;
      do_reset(1);
      wait_left = 5;
      s0 = stall_cnt;
      run_to_halt(100);
      chk("stall_cnt", 32'(stall_cnt - s0), 32'd5);
      chk("stall_r0", 32'(rf[0]), 32'h05);

      // Reset in EXEC of an ADD: no writeback, zero flag cleared
      clear_mem(8'hFF);
      mem[0] = 8'hB1; mem[1] = 8'h80; mem[2] = 8'h10;
      do_reset(1);
      f0 = fetch_cnt;
      wait_fetches(f0 + 3, 100);
      w0 = wb_cyc.size();
      do_reset(3);
      chk("rst_exec_nowb", 32'(wb_cyc.size()), 32'(w0));
      run_to_halt(100);
      chk("rst_exec_r0", 32'(rf[0]), 32'h01);

      // imem_valid never arrives
      clear_mem(8'hFF);
      do_reset(1);
      wait_left = 100000;
`ifdef IMEM_TIMEOUT_EN
      repeat (14) @(posedge clk);
      #1;
      chk("to_early_halt", 32'(halted), 32'd0);
      chk("to_early_ferr", 32'(fetch_err), 32'd0);
      @(posedge clk);
      #1;
      chk("to_halt", 32'(halted), 32'd1);
      chk("to_ferr", 32'(fetch_err), 32'd1);
      do_reset(1);
      wait_left = 100000;
`endif
      repeat (100) @(negedge clk);
      chk("wait_halted", 32'(halted), 32'd0);
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", 32'(imem_addr), 32'h00);
`ifndef IMEM_TIMEOUT_EN
      chk("wait_ferr", 32'(fetch_err), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle fetch/decode/execute/writeback controller for the 8-bit datapath.
- Sits directly upstream of the 2-entry x 8-bit register file:
  - drives its read selects, write enable, write select and write data;
  - consumes its two combinational read-data outputs.
- Fetches 8-bit instructions from instruction memory via a request/valid handshake.
- Holds the PC and zero flag; executes ADD, SUB, LDI, JZ and HALT.

Parameters:
- PC_RESET, 8'h00, PC value loaded on reset.
- TIMEOUT_CYCLES, 15, fetch wait limit in cycles; used only with the optional feature.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- imem_req  output  1  fetch request.
- imem_addr  output  8  fetch address (equals PC).
- imem_valid  input  1  instruction data valid; sampled only in FETCH.
- imem_data  input  8  instruction word.
- rf_read_reg1  output  1  register file read select 1.
- rf_read_reg2  output  1  register file read select 2.
- rf_reg_write  output  1  register file write enable.
- rf_write_reg  output  1  register file write select.
- rf_write_data  output  8  register file write data.
- rf_read_data1  input  8  register file read data 1.
- rf_read_data2  input  8  register file read data 2.
- zero_flag  output  1  Z flag from last ADD/SUB/LDI.
- halted  output  1  high in HALT state.
- fetch_err  output  1  imem timeout flag; tied 0 unless IMEM_TIMEOUT_EN is defined.

Behaviour:
- Instruction format: [7:6] op, [5] rd, [4] rs, [3:0] imm4.
  - op 00: ADD, rd = rd + rs.
  - op 01: SUB, rd = rd - rs.
  - op 10: LDI, rd = {4'h0, imm4}.
  - op 11 with [5:0]=6'h3F: HALT.
  - op 11 otherwise: JZ; if zero_flag, PC = {2'b00, [5:0]}, else fall through.
- Arithmetic: 8-bit modulo; carry/borrow discarded. Z = (result == 0).
- States: FETCH, DECODE, EXEC, WB, HALT. Reset state is FETCH, PC = PC_RESET.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - On an edge with imem_valid=1: IR <= imem_data, PC <= PC+1 (8'hFF wraps to 8'h00), go to DECODE.
  - Otherwise stay in FETCH with imem_req held high.
  - imem_valid may be asserted in the same cycle as the request.
- DECODE:
  - rf_read_reg1 = IR[5], rf_read_reg2 = IR[4].
  - HALT -> HALT.
  - JZ: if Z, PC <= target; then -> FETCH.
  - ADD/SUB/LDI -> EXEC.
- EXEC:
  - Read selects held.
  - Result register <= rf_read_data1 +/- rf_read_data2, or the LDI immediate.
  - zero_flag <= (result == 0).
  - -> WB.
- WB:
  - Exactly one cycle with rf_reg_write=1, rf_write_reg=IR[5], rf_read_reg1=IR[5], rf_write_data = result register.
  - -> FETCH.
- rf_reg_write is 0 in every state other than WB.
- HALT: terminal. halted=1, imem_req=0. Exit only via rst.
- Latency:
  - ALU/LDI instruction: 4 cycles with zero-wait memory (FETCH, DECODE, EXEC, WB).
  - JZ: 2 cycles.
- Reset (including mid-instruction), on the reset edge:
  - state=FETCH, PC=PC_RESET, IR=8'h00, result=8'h00, zero_flag=0, halted=0, fetch_err=0.
  - rf_reg_write=0 in the cycle after the reset edge; no partial writeback.
- Outputs during reset cycle:
  - imem_req=1, imem_addr=PC_RESET.
  - rf selects 0, rf_write_data 8'h00.

Optional Feature:
- Macro IMEM_TIMEOUT_EN.
- Defined:
  - A 4-bit-minimum wait counter counts consecutive FETCH cycles with imem_valid=0.
  - When the count reaches TIMEOUT_CYCLES: fetch_err <= 1 (sticky until rst), state -> HALT.
  - The counter clears on every FETCH entry and on reset.
- Not defined: no counter; FETCH waits indefinitely; fetch_err tied 0.

Test Plan:
- rst, then program LDI r0,5 (8'h85); LDI r1,3 (8'hB3); ADD r0,r1 (8'h10); zero-wait memory:
  - WB writes 8'h05 to r0, then 8'h03 to r1, then 8'h08 to r0.
  - rf_reg_write pulses exactly 3 times, 4 cycles apart.
- r0=3, r1=3, SUB r0,r1 (8'h50), then JZ 6'h20 (8'hE0):
  - r0 <- 8'h00, zero_flag=1.
  - Next imem_addr = 8'h20.
  - Repeat with r1=2: zero_flag=0, next imem_addr = PC+1.
- ADD with r0=8'hFF, r1=8'h02 -> writeback 8'h01, zero_flag=0. Also: PC at 8'hFF fetches, then imem_addr wraps to 8'h00.
- imem_valid held low 5 cycles in FETCH:
  - imem_req stays high, imem_addr stable, no state advance.
  - Valid on cycle 6 latches the instruction.
- HALT (8'hFF): halted=1, imem_req=0 indefinitely; rst returns to FETCH at PC_RESET. rst asserted during EXEC of ADD: no rf_reg_write occurs, zero_flag=0.
- IMEM_TIMEOUT_EN defined, imem_valid held low: after 15 FETCH cycles, fetch_err=1 and halted=1. Undefined: still in FETCH after 100 cycles.
